// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexed 7-segment driver. Packed BCD digits are captured into a
// shadow register and promoted to the displayed (active) copy only at a
// frame boundary, so a frame never mixes old and new digits. One digit is
// driven at a time on a shared segment bus with a one-hot digit enable.
// Leading-zero blanking, whole-display blink and a dash for non-BCD codes
// are applied on the way out.
//
// load is a single-cycle strobe with no back-pressure: every cycle it is
// high (outside reset) digits_in is taken, and the last one in a frame wins.

module display_scan_driver #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_DIV  = 8,
  parameter int LZ_KEEP    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          blank_lz,
  input  logic                          blink_en,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         dig_en,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    phase_q, phase_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    frame_done_q, frame_done_d;

  logic       div_last;
  logic       idx_last;
  logic       frame_wrap;
  logic [3:0] cur_val;
  logic [6:0] seg_dec;
  logic       blank;
  logic       all_zero;
  logic [NUM_DIGITS-1:0] dig_onehot;

  assign div_last   = (div_q == DW'(SCAN_DIV - 1));
  assign idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
  assign frame_wrap = div_last && idx_last;

  // Next-state: scan counters, shadow/active buffering, blink phase.
  always_comb begin
    div_d        = div_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    phase_d      = phase_q;
    bcnt_d       = bcnt_q;
    frame_done_d = frame_wrap;

    if (div_last) begin
      div_d = '0;
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    // A load landing on the wrap edge goes straight to the display; a
    // load anywhere else waits in the shadow until the next wrap.
    if (load && frame_wrap) begin
      shadow_d  = digits_in;
      active_d  = digits_in;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end else if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Dropping blink_en returns to the visible phase on the next edge.
    if (!blink_en) begin
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (frame_wrap) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      phase_q      <= 1'b0;
      bcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      phase_q      <= phase_d;
      bcnt_q       <= bcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Select the current digit, decide blanking, and build the one-hot enable.
  always_comb begin
    cur_val    = '0;
    dig_onehot = '0;
    blank      = 1'b0;
    all_zero   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_onehot[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) cur_val = active_q[4*i +: 4];
    end
    // Blank only when this digit and every more significant one are zero;
    // a dash code is nonzero and so keeps the digits below it visible.
    if (blank_lz) begin
      for (int i = LZ_KEEP; i < NUM_DIGITS; i++) begin
        if (idx_q == IW'(i)) begin
          all_zero = 1'b1;
          for (int j = i; j < NUM_DIGITS; j++) begin
            if (active_q[4*j +: 4] != 4'd0) all_zero = 1'b0;
          end
          blank = all_zero;
        end
      end
    end
  end

  // BCD to segments a..g (bit6 = a); non-BCD codes show a dash.
  always_comb begin
    case (cur_val)
      4'd0:    seg_dec = 7'b1111110;
      4'd1:    seg_dec = 7'b0110000;
      4'd2:    seg_dec = 7'b1101101;
      4'd3:    seg_dec = 7'b1111001;
      4'd4:    seg_dec = 7'b0110011;
      4'd5:    seg_dec = 7'b1011011;
      4'd6:    seg_dec = 7'b1011111;
      4'd7:    seg_dec = 7'b1110000;
      4'd8:    seg_dec = 7'b1111111;
      4'd9:    seg_dec = 7'b1111011;
      default: seg_dec = 7'b0000001;
    endcase
  end

  // Output gating: reset and the dark blink phase kill both buses.
  always_comb begin
    seg_out = '0;
    dig_en  = '0;
    if (!reset && !phase_q) begin
      dig_en = dig_onehot;
      if (!blank) seg_out = seg_dec;
    end
  end

  assign cur_digit  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver (3 digits, SCAN_DIV=4, BLINK_DIV=2).
// Each frame's expected outputs are pushed into exp_q from hand-written
// segment patterns, then popped and compared cycle by cycle.

module tb_display_scan_driver;

  localparam logic [6:0] S_0    = 7'b1111110;
  localparam logic [6:0] S_1    = 7'b0110000;
  localparam logic [6:0] S_3    = 7'b1111001;
  localparam logic [6:0] S_4    = 7'b0110011;
  localparam logic [6:0] S_5    = 7'b1011011;
  localparam logic [6:0] S_9    = 7'b1111011;
  localparam logic [6:0] S_DASH = 7'b0000001;
  localparam logic [6:0] S_OFF  = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [11:0] digits_in;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg_out;
  logic [2:0]  dig_en;
  logic [1:0]  cur_digit;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // {frame_done, cur_digit, dig_en, seg_out}
  logic [12:0] exp_q[$];

  display_scan_driver #(
    .NUM_DIGITS(3),
    .SCAN_DIV  (4),
    .BLINK_DIV (2),
    .LZ_KEEP   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .cur_digit (cur_digit),
    .frame_done(frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one 12-cycle frame; dark[c] marks cycles in the blink-off phase.
  task automatic push_frame(input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0,
                            input logic [11:0] dark, input bit fd_first);
    for (int c = 0; c < 12; c++) begin
      logic [1:0] idx;
      logic [2:0] en;
      logic [6:0] sg;
      logic       fd;
      idx = 2'(c / 4);
      sg  = (idx == 2'd0) ? s0 : (idx == 2'd1) ? s1 : s2;
      en  = 3'b001 << idx;
      if (dark[c]) begin
        sg = S_OFF;
        en = 3'b000;
      end
      fd = (c == 0) && fd_first;
      exp_q.push_back({fd, idx, en, sg});
    end
  endtask

  // Driver + scoreboard: called at posedge+1 of a frame's first cycle.
  task automatic run_cycles(input string tag, input int n,
                            input int ld_a, input logic [11:0] va,
                            input int ld_b, input logic [11:0] vb,
                            input int be_off);
    logic [12:0] e;
    for (int c = 0; c < n; c++) begin
      load = (c == ld_a) || (c == ld_b);
      digits_in = (c == ld_b) ? vb : va;
      if (c == be_off) blink_en = 1'b0;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check($sformatf("%s_c%0d_queue", tag, c), 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_c%0d_seg", tag, c), seg_out, e[6:0]);
        check($sformatf("%s_c%0d_en", tag, c), dig_en, e[9:7]);
        check($sformatf("%s_c%0d_idx", tag, c), cur_digit, e[11:10]);
        check($sformatf("%s_c%0d_fd", tag, c), frame_done, e[12]);
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0; blank_lz = 1'b0; blink_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // A load while in reset must be ignored.
    load = 1'b1; digits_in = 12'h999;
    @(negedge clk);
    check("rst_seg", seg_out, 0);
    check("rst_en", dig_en, 0);
    check("rst_fd", frame_done, 0);
    check("rst_idx", cur_digit, 0);
    @(posedge clk); #1;
    load = 1'b0; reset = 1'b0;

    // Idle frame; load 130 mid-frame, which must not tear.
    push_frame(S_0, S_0, S_0, 12'h000, 1'b0);
    run_cycles("idle", 12, 4, 12'h130, -1, 12'h000, -1);
    // 130 shown; load 005 on the wrap edge.
    push_frame(S_1, S_3, S_0, 12'h000, 1'b1);
    run_cycles("show130", 12, 11, 12'h005, -1, 12'h000, -1);
    // 005 with blanking, shown immediately after the wrap-edge load.
    blank_lz = 1'b1;
    push_frame(S_OFF, S_OFF, S_5, 12'h000, 1'b1);
    run_cycles("lz005", 12, 6, 12'h000, -1, 12'h000, -1);
    // 000: lowest digit kept; two loads in this frame, second wins.
    push_frame(S_OFF, S_OFF, S_0, 12'h000, 1'b1);
    run_cycles("lz000", 12, 2, 12'h777, 8, 12'hA09, -1);
    // A09: dash on top keeps the middle zero visible.
    push_frame(S_DASH, S_0, S_9, 12'h000, 1'b1);
    run_cycles("dashA09", 12, 9, 12'h040, -1, 12'h000, -1);
    push_frame(S_OFF, S_4, S_0, 12'h000, 1'b1);
    run_cycles("lz040", 12, -1, 12'h000, -1, 12'h000, -1);

    // Blink: 2 frames on, 2 frames off.
    blank_lz = 1'b0;
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      push_frame(S_0, S_4, S_0, (f == 2 || f == 3) ? 12'hFFF : 12'h000, 1'b1);
      run_cycles($sformatf("blink%0d", f), 12, -1, 12'h000, -1, 12'h000, -1);
    end
    // Dark again; dropping blink_en at cycle 5 lights cycle 6 onward.
    push_frame(S_0, S_4, S_0, 12'h03F, 1'b1);
    run_cycles("blinkdrop", 12, -1, 12'h000, -1, 12'h000, 5);
    push_frame(S_0, S_4, S_0, 12'h000, 1'b1);
    run_cycles("blinkoff", 12, -1, 12'h000, -1, 12'h000, -1);

    // Reset mid-frame with a load pending.
    push_frame(S_0, S_4, S_0, 12'h000, 1'b1);
    run_cycles("prerst", 6, 3, 12'h321, -1, 12'h000, -1);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_seg", seg_out, 0);
    check("midrst_en", dig_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_idx", cur_digit, 0);
    check("midrst_fd", frame_done, 0);
    check("midrst_seg2", seg_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_frame(S_0, S_0, S_0, 12'h000, 1'b0);
    run_cycles("postrst0", 12, -1, 12'h000, -1, 12'h000, -1);
    push_frame(S_0, S_0, S_0, 12'h000, 1'b1);
    run_cycles("postrst1", 12, -1, 12'h000, -1, 12'h000, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
